// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: edge-captured write requests from NREQ requesters are
// buffered and granted round-robin into a shared bank of 2**AW registers,
// one write per clk.
module reg_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 4,
  parameter int AW   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DW-1:0]        wdata,
  input  logic [NREQ*AW-1:0]        waddr,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           pending,
  output logic [(2**AW)*DW-1:0]     regs_out,
  output logic [7:0]                overrun_cnt,
  output logic [7:0]                conflict_cnt
);

  localparam int DEPTH = 2 ** AW;
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req_d_q;
  logic [NREQ-1:0] rise;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   buf_addr_q [NREQ];
  logic [DW-1:0]   buf_data_q [NREQ];
  logic [DW-1:0]   bank_q     [DEPTH];
  logic [7:0]      overrun_q, overrun_d;
  logic [7:0]      conflict_q, conflict_d;

  logic            grant;
  logic            sel_found;
  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   cand;
  logic [NREQ-1:0] sel_onehot;
  logic [NREQ-1:0] overrun_vec;
  logic [8:0]      overrun_sum;

  assign rise = req & ~req_d_q;

  // Round-robin search: first pending bit at ptr, ptr+1, ... modulo NREQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PW'((32'(ptr_q) + k) % NREQ);
      if (!sel_found && pending_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign grant      = !hold && sel_found;
  assign sel_onehot = grant ? (NREQ'(1) << sel_idx) : '0;

  // Next pending: the granted entry clears first so a same-cycle rise re-arms it.
  always_comb begin
    pending_d = (pending_q & ~sel_onehot) | rise;
    gnt_d     = sel_onehot;
    ptr_d     = ptr_q;
    if (grant) begin
      ptr_d = (32'(sel_idx) == NREQ - 1) ? '0 : PW'(sel_idx + 1'b1);
    end
  end

  // Saturating event counters; every overwriting capture counts once.
  always_comb begin
    overrun_vec = rise & pending_q & ~sel_onehot;
    overrun_sum = {1'b0, overrun_q} + 9'($countones(overrun_vec));
    overrun_d   = overrun_sum[8] ? 8'hFF : overrun_sum[7:0];
    conflict_d  = conflict_q;
    if (grant && ($countones(pending_q) >= 2) && (conflict_q != 8'hFF)) begin
      conflict_d = conflict_q + 8'd1;
    end
  end

  // Edge detection, request capture and pending flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d_q   <= '0;
      pending_q <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        buf_addr_q[i] <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      req_d_q   <= req;
      pending_q <= pending_d;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (rise[i]) begin
          buf_addr_q[i] <= waddr[i*AW +: AW];
          buf_data_q[i] <= wdata[i*DW +: DW];
        end
      end
    end
  end

  // Grant pulse, pointer advance and the bank write from the pre-capture buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q <= '0;
      ptr_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        bank_q[k] <= '0;
      end
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      if (grant) begin
        bank_q[buf_addr_q[sel_idx]] <= buf_data_q[sel_idx];
      end
    end
  end

  // Statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q  <= '0;
      conflict_q <= '0;
    end else begin
      overrun_q  <= overrun_d;
      conflict_q <= conflict_d;
    end
  end

  // Flatten the bank for the display decoders.
  always_comb begin
    regs_out = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      regs_out[k*DW +: DW] = bank_q[k];
    end
  end

  assign gnt          = gnt_q;
  assign pending      = pending_q;
  assign overrun_cnt  = overrun_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios with literal expectations
// plus randomized traffic, all checked against a transaction-level model.
module tb_reg_write_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 2 ** AW;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  hold;
  logic [NREQ-1:0]       req;
  logic [NREQ*DW-1:0]    wdata;
  logic [NREQ*AW-1:0]    waddr;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       pending;
  logic [DEPTH*DW-1:0]   regs_out;
  logic [7:0]            overrun_cnt;
  logic [7:0]            conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  reg_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .hold(hold), .req(req), .wdata(wdata), .waddr(waddr),
    .gnt(gnt), .pending(pending), .regs_out(regs_out),
    .overrun_cnt(overrun_cnt), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [NREQ-1:0] m_pend, m_gnt, m_prev;
  logic [AW-1:0]   m_baddr [NREQ];
  logic [DW-1:0]   m_bdata [NREQ];
  logic [DW-1:0]   m_regs  [DEPTH];
  int              m_ptr, m_ovr, m_conf;

  task automatic model_clear();
    m_pend = '0; m_gnt = '0; m_prev = '0;
    m_ptr = 0; m_ovr = 0; m_conf = 0;
    for (int i = 0; i < NREQ; i++) begin m_baddr[i] = '0; m_bdata[i] = '0; end
    for (int k = 0; k < DEPTH; k++) m_regs[k] = '0;
  endtask

  task automatic model_step();
    int sel, np;
    np = $countones(m_pend);
    sel = -1;
    m_gnt = '0;
    if (!hold && np > 0) begin
      for (int k = 0; k < NREQ; k++)
        if (sel < 0 && m_pend[(m_ptr + k) % NREQ]) sel = (m_ptr + k) % NREQ;
      m_regs[m_baddr[sel]] = m_bdata[sel];
      m_gnt[sel] = 1'b1;
      m_pend[sel] = 1'b0;
      m_ptr = (sel + 1) % NREQ;
      if (np >= 2 && m_conf < 255) m_conf++;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && !m_prev[i]) begin
        if (m_pend[i] && m_ovr < 255) m_ovr++;
        m_pend[i]  = 1'b1;
        m_baddr[i] = waddr[i*AW +: AW];
        m_bdata[i] = wdata[i*DW +: DW];
      end
    end
    m_prev = req;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_clear();
    else     model_step();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [DEPTH*DW-1:0] er;
    er = '0;
    for (int k = 0; k < DEPTH; k++) er[k*DW +: DW] = m_regs[k];
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("regs_out", 32'(regs_out), 32'(er));
    chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  int gcount;

  initial begin
    rst = 1'b1; hold = 1'b0; req = '0; wdata = '0; waddr = '0;
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    chk("reset_regs", 32'(regs_out), 32'h0);
    chk("reset_gnt", 32'(gnt), 32'h0);

    // T1: single request, 2-clk latency
    waddr[1:0] = 2'd2; wdata[3:0] = 4'hA; req = 4'b0001;
    tick();
    chk("t1_pending", 32'(pending), 32'h1);
    chk("t1_gnt_early", 32'(gnt), 32'h0);
    tick();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_regs", 32'(regs_out), 32'h0A00);
    tick();
    chk("t1_gnt_pulse", 32'(gnt), 32'h0);
    req = '0;
    tick();
    do_reset();

    // T2: all four rise together
    waddr = {2'd3, 2'd2, 2'd1, 2'd0}; wdata = 16'h4321; req = 4'b1111;
    tick();
    chk("t2_pending", 32'(pending), 32'hF);
    req = '0;
    tick(); chk("t2_gnt0", 32'(gnt), 32'h1);
    tick(); chk("t2_gnt1", 32'(gnt), 32'h2);
    tick(); chk("t2_gnt2", 32'(gnt), 32'h4);
    tick(); chk("t2_gnt3", 32'(gnt), 32'h8);
    tick();
    chk("t2_regs", 32'(regs_out), 32'h4321);
    chk("t2_conflict", 32'(conflict_cnt), 32'd3);

    // T3: two requesters to the same address
    waddr = '0; wdata = 16'h0560; req = 4'b0110;
    tick(); req = '0;
    tick();
    chk("t3_gnt1", 32'(gnt), 32'h2);
    chk("t3_regs_a", 32'(regs_out), 32'h4326);
    tick();
    chk("t3_gnt2", 32'(gnt), 32'h4);
    chk("t3_regs_b", 32'(regs_out), 32'h4325);

    // T4: overrun while held
    hold = 1'b1; waddr[1:0] = 2'd3; wdata[3:0] = 4'h7; req = 4'b0001;
    tick(); chk("t4_gnt_hold", 32'(gnt), 32'h0);
    req = '0;
    tick();
    wdata[3:0] = 4'h9; req = 4'b0001;
    tick();
    chk("t4_overrun", 32'(overrun_cnt), 32'd1);
    chk("t4_gnt_hold2", 32'(gnt), 32'h0);
    req = '0; hold = 1'b0;
    tick();
    chk("t4_gnt", 32'(gnt), 32'h1);
    chk("t4_regs", 32'(regs_out), 32'h9325);
    tick();

    // T5: held request -> one grant; overrun saturation
    req = 4'b0010; gcount = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (gnt[1]) gcount++; end
    req = '0;
    tick(); if (gnt[1]) gcount++;
    chk("t5_one_gnt", 32'(gcount), 32'd1);
    hold = 1'b1;
    for (int i = 0; i < 300; i++) begin
      req = 4'b0001; tick();
      req = '0;      tick();
    end
    chk("t5_ovr_sat", 32'(overrun_cnt), 32'hFF);
    hold = 1'b0;
    tick(); tick();

    // T6: async reset with entries pending
    hold = 1'b1; req = 4'b0111;
    tick();
    chk("t6_pending", 32'(pending), 32'h7);
    #2 rst = 1'b1; req = 4'b0100;
    #1;
    chk("t6_rst_pending", 32'(pending), 32'h0);
    chk("t6_rst_regs", 32'(regs_out), 32'h0);
    chk("t6_rst_ovr", 32'(overrun_cnt), 32'h0);
    tick();
    rst = 1'b0; hold = 1'b0;
    tick(); chk("t6_recapture", 32'(pending), 32'h4);
    tick(); chk("t6_gnt", 32'(gnt), 32'h4);
    req = '0;
    tick(); chk("t6_idle", 32'(pending | gnt), 32'h0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      req   = NREQ'($urandom);
      hold  = ($urandom_range(0, 7) == 0);
      wdata = (NREQ*DW)'($urandom);
      waddr = (NREQ*AW)'($urandom);
      rst   = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
